// File: rtl/bram_dual_port.sv
// Simple dual-port block RAM: one write port, one read port, one clock.
// Per-lane write enables, selectable read-during-write behaviour, optional
// output register and an optional post-reset clear engine. The array itself
// is never reset so that it maps onto a block RAM; only control and output
// state sit on rst_n.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zeroing one word per cycle, user traffic ignored, ready=0
// ST_RUN   | normal operation, ready=1 until the next reset
module bram_dual_port #(
   parameter int WordLengthBits = 8,
   parameter int NumWords       = 128,
   parameter int LaneBits       = 8,
   parameter int ReadMode       = 0,
   parameter int OutputRegister = 0,
   parameter int ClearOnReset   = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   output logic                                 ready,
   input  logic                                 write_enable,
   input  logic [$clog2(NumWords)-1:0]          write_address,
   input  logic [WordLengthBits/LaneBits-1:0]   write_lane_enable,
   input  logic [WordLengthBits-1:0]            data_in,
   input  logic                                 read_enable,
   input  logic [$clog2(NumWords)-1:0]          read_address,
   output logic [WordLengthBits-1:0]            data_out,
   output logic                                 data_out_valid
);

   localparam int NumLanes = WordLengthBits / LaneBits;
   localparam int AW       = $clog2(NumWords);

   // Depth widened by one bit so the range check also works for
   // power-of-two depths, where every address is legal.
   localparam logic [AW:0]   DEPTH     = (AW + 1)'(NumWords);
   localparam logic [AW-1:0] LAST_ADDR = AW'(NumWords - 1);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;
   localparam logic [0:0] ST_RESET = (ClearOnReset != 0) ? ST_CLEAR : ST_RUN;

   logic [WordLengthBits-1:0] mem [NumWords];

   logic [0:0]                state;
   logic [0:0]                state_nxt;
   logic [AW-1:0]             clr_cnt;

   logic                      user_wr;
   logic                      rd_fire;
   logic                      wr_in_range;
   logic                      rd_in_range;

   logic                      mem_we;
   logic [AW-1:0]             mem_addr;
   logic [NumLanes-1:0]       mem_lanes;
   logic [WordLengthBits-1:0] mem_wdata;

   logic [WordLengthBits-1:0] rd_old;
   logic [WordLengthBits-1:0] rd_word;
   logic [WordLengthBits-1:0] rd_data_q;
   logic                      rd_valid_q;

   assign user_wr     = write_enable & ready;
   assign rd_fire     = read_enable & ready;
   assign wr_in_range = ({1'b0, write_address} < DEPTH);
   assign rd_in_range = ({1'b0, read_address} < DEPTH);

   // Next-state: the clear engine hands over to RUN right after its last word.
   always_comb begin
      state_nxt = state;
      if (state == ST_CLEAR && clr_cnt == LAST_ADDR) begin
         state_nxt = ST_RUN;
      end
   end

   // Controller state, clear counter and ready. ready follows the next state
   // so it rises on the same edge that writes the last cleared word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_RESET;
         clr_cnt <= '0;
         ready   <= 1'b0;
      end else begin
         state <= state_nxt;
         ready <= (state_nxt == ST_RUN);
         if (state == ST_CLEAR && state_nxt == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
         end
      end
   end

   // Write-port mux: the clear engine owns the port while clearing.
   always_comb begin
      mem_we    = user_wr & wr_in_range;
      mem_addr  = write_address;
      mem_lanes = write_lane_enable;
      mem_wdata = data_in;
      if (state == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_addr  = clr_cnt;
         mem_lanes = '1;
         mem_wdata = '0;
      end
   end

   // Storage array with per-lane writes; deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NumLanes; i++) begin
            if (mem_lanes[i]) begin
               mem[mem_addr][i*LaneBits +: LaneBits] <= mem_wdata[i*LaneBits +: LaneBits];
            end
         end
      end
   end

   // Read word selection: out-of-range reads yield zero; in write-first mode
   // a same-address write forwards its enabled lanes into the result.
   always_comb begin
      rd_old  = rd_in_range ? mem[read_address] : '0;
      rd_word = rd_old;
      if (ReadMode == 0 && user_wr && wr_in_range && write_address == read_address) begin
         for (int i = 0; i < NumLanes; i++) begin
            if (write_lane_enable[i]) begin
               rd_word[i*LaneBits +: LaneBits] = data_in[i*LaneBits +: LaneBits];
            end
         end
      end
   end

   // First read stage: data register only loads on an accepted read so the
   // output holds the previous result between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_fire;
         if (rd_fire) begin
            rd_data_q <= rd_word;
         end
      end
   end

   if (OutputRegister != 0) begin : g_out_reg
      logic [WordLengthBits-1:0] out_data_q;
      logic                      out_valid_q;

      // Second read stage, again loading only with a valid result.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
         end else begin
            out_valid_q <= rd_valid_q;
            if (rd_valid_q) begin
               out_data_q <= rd_data_q;
            end
         end
      end

      assign data_out       = out_data_q;
      assign data_out_valid = out_valid_q;
   end else begin : g_no_out_reg
      assign data_out       = rd_data_q;
      assign data_out_valid = rd_valid_q;
   end

endmodule

// File: tb/tb_bram_dual_port.sv
// Directed bench for bram_dual_port. Four instances share one stimulus bus:
//   d0: defaults (8-bit, 128 words, write-first, no output reg, clear)
//   d1: 32-bit, 128 words, write-first, output reg, clear
//   d2: 32-bit, 128 words, read-first, no output reg, no clear
//   d3: 8-bit, 100 words, write-first, no output reg, clear
module tb_bram_dual_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic        re;
   logic [6:0]  waddr;
   logic [6:0]  raddr;
   logic [3:0]  mask;
   logic [31:0] din;

   logic        rdy0, rdy1, rdy2, rdy3;
   logic        vld0, vld1, vld2, vld3;
   logic [7:0]  dout0, dout3;
   logic [31:0] dout1, dout2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bram_dual_port #(.WordLengthBits(8), .NumWords(128), .LaneBits(8),
                    .ReadMode(0), .OutputRegister(0), .ClearOnReset(1)) d0 (
      .clk(clk), .rst_n(rst_n), .ready(rdy0),
      .write_enable(we), .write_address(waddr), .write_lane_enable(mask[0:0]),
      .data_in(din[7:0]), .read_enable(re), .read_address(raddr),
      .data_out(dout0), .data_out_valid(vld0));

   bram_dual_port #(.WordLengthBits(32), .NumWords(128), .LaneBits(8),
                    .ReadMode(0), .OutputRegister(1), .ClearOnReset(1)) d1 (
      .clk(clk), .rst_n(rst_n), .ready(rdy1),
      .write_enable(we), .write_address(waddr), .write_lane_enable(mask),
      .data_in(din), .read_enable(re), .read_address(raddr),
      .data_out(dout1), .data_out_valid(vld1));

   bram_dual_port #(.WordLengthBits(32), .NumWords(128), .LaneBits(8),
                    .ReadMode(1), .OutputRegister(0), .ClearOnReset(0)) d2 (
      .clk(clk), .rst_n(rst_n), .ready(rdy2),
      .write_enable(we), .write_address(waddr), .write_lane_enable(mask),
      .data_in(din), .read_enable(re), .read_address(raddr),
      .data_out(dout2), .data_out_valid(vld2));

   bram_dual_port #(.WordLengthBits(8), .NumWords(100), .LaneBits(8),
                    .ReadMode(0), .OutputRegister(0), .ClearOnReset(1)) d3 (
      .clk(clk), .rst_n(rst_n), .ready(rdy3),
      .write_enable(we), .write_address(waddr), .write_lane_enable(mask[0:0]),
      .data_in(din[7:0]), .read_enable(re), .read_address(raddr),
      .data_out(dout3), .data_out_valid(vld3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [6:0] a, input logic [3:0] m, input logic [31:0] d);
      we    = 1'b1;
      waddr = a;
      mask  = m;
      din   = d;
      tick();
      we    = 1'b0;
   endtask

   // Counts edges after reset release until each instance raises ready.
   task automatic wait_ready(output int e0, output int e1, output int e2,
                             output int e3, output logic saw_vld1);
      e0 = 0; e1 = 0; e2 = 0; e3 = 0;
      saw_vld1 = 1'b0;
      for (int n = 1; n <= 300; n++) begin
         tick();
         if (vld1) saw_vld1 = 1'b1;
         if (e0 == 0 && rdy0) e0 = n;
         if (e1 == 0 && rdy1) e1 = n;
         if (e2 == 0 && rdy2) e2 = n;
         if (e3 == 0 && rdy3) e3 = n;
         if (e0 != 0 && e1 != 0 && e2 != 0 && e3 != 0) break;
      end
   endtask

   initial begin
      int   e0, e1, e2, e3;
      logic saw;

      rst_n = 1'b0;
      we = 1'b0; re = 1'b0;
      waddr = '0; raddr = '0; mask = '0; din = '0;

      // Reset state
      tick(); tick();
      chk("rst_rdy0", 32'(rdy0), 32'd0);
      chk("rst_rdy2", 32'(rdy2), 32'd0);
      chk("rst_vld0", 32'(vld0), 32'd0);
      chk("rst_dout0", 32'(dout0), 32'h0);
      chk("rst_dout1", dout1, 32'h0);

      // Clear sequence timing
      rst_n = 1'b1;
      wait_ready(e0, e1, e2, e3, saw);
      chk("ready_edge_d0", 32'(e0), 32'd128);
      chk("ready_edge_d1", 32'(e1), 32'd128);
      chk("ready_edge_d2", 32'(e2), 32'd1);
      chk("ready_edge_d3", 32'(e3), 32'd100);

      // All words cleared, one valid per read, latency 1
      for (int a = 0; a < 128; a++) begin
         re = 1'b1; raddr = 7'(a);
         tick();
         chk("clr_vld0", 32'(vld0), 32'd1);
         chk("clr_dat0", 32'(dout0), 32'h0);
      end
      re = 1'b0;
      tick();
      chk("clr_vld0_end", 32'(vld0), 32'd0);

      // Lane mask and all-zero mask
      wr(7'd5, 4'hF, 32'hAABBCCDD);
      wr(7'd5, 4'b0101, 32'h11223344);
      wr(7'd5, 4'b0000, 32'hFFFFFFFF);
      re = 1'b1; raddr = 7'd5;
      tick();
      re = 1'b0;
      chk("mask_d2", dout2, 32'hAA22CC44);
      chk("mask_vld2", 32'(vld2), 32'd1);
      chk("mask_d0", 32'(dout0), 32'h44);
      tick();
      chk("mask_d1", dout1, 32'hAA22CC44);
      chk("mask_vld1", 32'(vld1), 32'd1);

      // Same-address collision
      wr(7'd7, 4'hF, 32'hAABBCCDD);
      we = 1'b1; waddr = 7'd7; mask = 4'b0101; din = 32'h11223344;
      re = 1'b1; raddr = 7'd7;
      tick();
      we = 1'b0; re = 1'b0;
      chk("coll_rf_d2", dout2, 32'hAABBCCDD);
      chk("coll_wf_d0", 32'(dout0), 32'h44);
      tick();
      chk("coll_wf_d1", dout1, 32'hAA22CC44);
      re = 1'b1; raddr = 7'd7;
      tick();
      re = 1'b0;
      chk("coll_after_d2", dout2, 32'hAA22CC44);
      tick();
      chk("coll_after_d1", dout1, 32'hAA22CC44);

      // Back-to-back reads through the output register
      for (int i = 0; i < 10; i++) wr(7'(i), 4'hF, 32'(i));
      for (int i = 0; i < 10; i++) begin
         re = 1'b1; raddr = 7'(i);
         tick();
         chk("b2b_d2", dout2, 32'(i));
         if (i == 0) begin
            chk("b2b_first_vld1", 32'(vld1), 32'd0);
         end else begin
            chk("b2b_vld1", 32'(vld1), 32'd1);
            chk("b2b_d1", dout1, 32'(i - 1));
         end
      end
      re = 1'b0;
      tick();
      chk("b2b_last_vld1", 32'(vld1), 32'd1);
      chk("b2b_last_d1", dout1, 32'd9);
      tick();
      chk("b2b_idle_vld1", 32'(vld1), 32'd0);
      chk("b2b_hold_d1", dout1, 32'd9);

      // Out-of-range address on the 100-word instance
      wr(7'd20, 4'hF, 32'h33);
      wr(7'd120, 4'hF, 32'h5A);
      re = 1'b1; raddr = 7'd120;
      tick();
      chk("oor_vld3", 32'(vld3), 32'd1);
      chk("oor_dat3", 32'(dout3), 32'h00);
      chk("oor_d0_inrange", 32'(dout0), 32'h5A);
      raddr = 7'd20;
      tick();
      re = 1'b0;
      chk("oor_addr20_d3", 32'(dout3), 32'h33);

      // Reset while a read is in flight on the output-register instance
      re = 1'b1; raddr = 7'd3;
      tick();
      re = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_dout1", dout1, 32'h0);
      chk("mid_rst_vld1", 32'(vld1), 32'd0);
      chk("mid_rst_rdy1", 32'(rdy1), 32'd0);
      tick();
      chk("mid_rst_vld1_edge", 32'(vld1), 32'd0);
      rst_n = 1'b1;
      wait_ready(e0, e1, e2, e3, saw);
      chk("rerst_ready_d1", 32'(e1), 32'd128);
      chk("rerst_no_vld1", 32'(saw), 32'd0);
      for (int a = 0; a < 128; a++) begin
         re = 1'b1; raddr = 7'(a);
         tick();
         if (a > 0) begin
            chk("reclr_vld1", 32'(vld1), 32'd1);
            chk("reclr_d1", dout1, 32'h0);
         end
      end
      re = 1'b0;
      tick();
      chk("reclr_last_vld1", 32'(vld1), 32'd1);
      chk("reclr_last_d1", dout1, 32'h0);
      tick();
      chk("reclr_idle_vld1", 32'(vld1), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
